mod_symbol_framer: RTL and testbench

- Upstream feeder of the modulator datapath.
- Latches the 10-bit switch message on a start request and wraps it in a frame: preamble, then data MSB-first, then an even-parity bit.
- Emits the frame one bit per symbol period with a per-symbol strobe, so the modulator (ASK/FSK/PSK sample generator driving the 8-bit out) consumes exactly one bit per symbol.
- Supports one-shot and continuous-repeat framing.

---
 rtl/mod_symbol_framer_pkg.sv | 20 ++
 rtl/mod_symbol_framer_if.sv | 23 ++
 rtl/mod_symbol_framer_timer.sv | 34 +++
 rtl/mod_symbol_framer.sv | 154 +++++++++++++++
 tb/tb_mod_symbol_framer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mod_symbol_framer_pkg.sv
// Shared constants for the symbol framer and the modulator datapath it feeds.
// Holds the message width, default preamble, FSM state codes and a parity helper.
package mod_pkg;

    localparam int          MOD_MSG_W    = 10;
    localparam int          MOD_PRE_W    = 4;
    localparam logic [3:0]  MOD_PREAMBLE = 4'b1010;

    // State encoding, kept as plain constants so older tools can share it.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_PAR  = 2'd3;

    // Bit that makes the count of ones in {msg, bit} even.
    function automatic logic even_par(input logic [MOD_MSG_W-1:0] msg);
        return ^msg;
    endfunction

endpackage

// File: rtl/mod_symbol_framer_if.sv
// Request and symbol-stream bundle between a frame requester and the symbol framer.
interface mod_symbol_framer_if #(
    parameter int MSG_W = mod_pkg::MOD_MSG_W
);
    logic             start;
    logic             mode;
    logic [MSG_W-1:0] sw;
    logic             sym;
    logic             sym_valid;
    logic             sym_strobe;
    logic             busy;
    logic             frame_done;

    modport master (
        output start, mode, sw,
        input  sym, sym_valid, sym_strobe, busy, frame_done
    );

    modport slave (
        input  start, mode, sw,
        output sym, sym_valid, sym_strobe, busy, frame_done
    );
endinterface

// File: rtl/mod_symbol_framer_timer.sv
// Symbol-period counter: runs 0..SYM_CYCLES-1 while enabled, rests at 0 otherwise.
module mod_symbol_timer #(
    parameter int SYM_CYCLES = 1000,
    parameter int CNT_W      = $clog2(SYM_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic sym_first,
    output logic sym_last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sym_first = (cnt_q == '0);
    assign sym_last  = (cnt_q == CNT_W'(SYM_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || !en || sym_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mod_symbol_framer.sv
// Symbol framer: wraps the switch message as preamble + data (MSB-first) + even parity
// and emits one bit per symbol period, optionally repeating frames back-to-back.
module mod_symbol_framer
    import mod_pkg::*;
#(
    parameter int               MSG_W      = MOD_MSG_W,
    parameter int               PRE_W      = MOD_PRE_W,
    parameter logic [PRE_W-1:0] PREAMBLE   = MOD_PREAMBLE,
    parameter int               SYM_CYCLES = 1000,
    parameter int               CNT_W      = $clog2(SYM_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    mod_symbol_framer_if.slave   bus
);

    localparam int BIT_W = $clog2(MSG_W);

    logic [1:0]       state_q, state_d;
    logic             start_d_q, start_d_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic             par_q, par_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             sym_q, sym_d;
    logic             frame_done_q, frame_done_d;
    logic             sym_first, sym_last;
    logic             active;
    logic             launch;

    assign active = (state_q != ST_IDLE);
    assign launch = !active && bus.start && !start_d_q;

    mod_symbol_timer #(
        .SYM_CYCLES (SYM_CYCLES),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (active),
        .clr       (init),
        .sym_first (sym_first),
        .sym_last  (sym_last)
    );

    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        par_d        = par_q;
        pre_d        = pre_q;
        bit_cnt_d    = bit_cnt_q;
        sym_d        = sym_q;
        frame_done_d = 1'b0;
        // start_d clears to 1 so a start level already present is never taken as an edge.
        start_d_d    = init ? 1'b1 : bus.start;

        if (init) begin
            state_d   = ST_IDLE;
            msg_d     = '0;
            par_d     = 1'b0;
            pre_d     = '0;
            bit_cnt_d = '0;
            sym_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_d   = ST_PRE;
                        bit_cnt_d = '0;
                        sym_d     = PREAMBLE[PRE_W-1];
                        pre_d     = {PREAMBLE[PRE_W-2:0], 1'b0};
                        msg_d     = bus.sw;
                        par_d     = even_par(bus.sw);
                    end
                end
                ST_PRE: begin
                    if (sym_last) begin
                        if (bit_cnt_q == BIT_W'(PRE_W - 1)) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = '0;
                            sym_d     = msg_q[MSG_W-1];
                            msg_d     = {msg_q[MSG_W-2:0], 1'b0};
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            sym_d     = pre_q[PRE_W-1];
                            pre_d     = {pre_q[PRE_W-2:0], 1'b0};
                        end
                    end
                end
                ST_DATA: begin
                    if (sym_last) begin
                        if (bit_cnt_q == BIT_W'(MSG_W - 1)) begin
                            state_d   = ST_PAR;
                            bit_cnt_d = '0;
                            sym_d     = par_q;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            sym_d     = msg_q[MSG_W-1];
                            msg_d     = {msg_q[MSG_W-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    if (sym_last) begin
                        frame_done_d = 1'b1;
                        // Repeat re-latches sw and restarts the preamble with no idle gap.
                        if (bus.mode && bus.start) begin
                            state_d   = ST_PRE;
                            bit_cnt_d = '0;
                            sym_d     = PREAMBLE[PRE_W-1];
                            pre_d     = {PREAMBLE[PRE_W-2:0], 1'b0};
                            msg_d     = bus.sw;
                            par_d     = even_par(bus.sw);
                        end else begin
                            state_d   = ST_IDLE;
                            bit_cnt_d = '0;
                            sym_d     = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            start_d_q    <= 1'b1;
            msg_q        <= '0;
            par_q        <= 1'b0;
            pre_q        <= '0;
            bit_cnt_q    <= '0;
            sym_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_d_q    <= start_d_d;
            msg_q        <= msg_d;
            par_q        <= par_d;
            pre_q        <= pre_d;
            bit_cnt_q    <= bit_cnt_d;
            sym_q        <= sym_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.sym        = sym_q;
    assign bus.sym_valid  = active;
    assign bus.busy       = active;
    assign bus.sym_strobe = active && sym_first;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_mod_symbol_framer.sv
// Bench for mod_symbol_framer: frame-position model checked every cycle plus literal frame checks.
module tb_mod_symbol_framer;
    import mod_pkg::*;

    localparam int         SYM  = 4;
    localparam int         MW   = 10;
    localparam int         PW   = 4;
    localparam int         TOT  = PW + MW + 1;
    localparam int         LAST = TOT * SYM - 1;
    localparam logic [3:0] PRE  = 4'b1010;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic init  = 1'b0;

    always #5 clk = ~clk;

    mod_symbol_framer_if #(.MSG_W(MW)) bus ();

    mod_symbol_framer #(
        .MSG_W      (MW),
        .PRE_W      (PW),
        .PREAMBLE   (PRE),
        .SYM_CYCLES (SYM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (init),
        .bus   (bus)
    );

    // Model: a frame is a bit string {preamble, msg, parity}; k is the cycle offset into it.
    function automatic logic [TOT-1:0] frame_of(input logic [MW-1:0] m);
        return {PRE, m, ^m};
    endfunction

    logic           m_act, m_done, m_start_d;
    int             m_k;
    logic [TOT-1:0] m_bits;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || init) begin
            m_act     <= 1'b0;
            m_done    <= 1'b0;
            m_start_d <= 1'b1;
            m_k       <= 0;
            m_bits    <= '0;
        end else begin
            m_start_d <= bus.start;
            m_done    <= m_act && (m_k == LAST);
            if (!m_act) begin
                if (bus.start && !m_start_d) begin
                    m_act  <= 1'b1;
                    m_k    <= 0;
                    m_bits <= frame_of(bus.sw);
                end
            end else if (m_k == LAST) begin
                if (bus.mode && bus.start) begin
                    m_k    <= 0;
                    m_bits <= frame_of(bus.sw);
                end else begin
                    m_act <= 1'b0;
                    m_k   <= 0;
                end
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    function automatic logic [4:0] exp_outs();
        logic s;
        s = m_act ? m_bits[TOT-1-(m_k/SYM)] : 1'b0;
        return {s, m_act, m_act && (m_k % SYM == 0), m_act, m_done};
    endfunction

    function automatic logic [4:0] dut_outs();
        return {bus.sym, bus.sym_valid, bus.sym_strobe, bus.busy, bus.frame_done};
    endfunction

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    endtask

    logic [63:0] cap;
    int          ns, ndone, done_at, first_st, n_coinc, cyc;

    task automatic clear_cap();
        cap = '0; ns = 0; ndone = 0; done_at = -1; first_st = -1; n_coinc = 0; cyc = 0;
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            cyc++;
            if (bus.sym_strobe) begin
                cap = {cap[62:0], bus.sym};
                ns++;
                if (first_st < 0) first_st = cyc;
            end
            if (bus.frame_done) begin
                ndone++;
                if (done_at < 0) done_at = cyc;
                if (bus.sym_strobe && bus.sym_valid) n_coinc++;
            end
        end
    endtask

    task automatic launch(input logic [MW-1:0] m, input logic md);
        @(posedge clk);
        #2;
        bus.sw    = m;
        bus.mode  = md;
        bus.start = 1'b1;
        @(posedge clk);
        clear_cap();
    endtask

    localparam logic [MW-1:0] SW_A = 10'b1000110101;
    localparam logic [MW-1:0] SW_B = 10'b1001101101;

    initial begin
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.sw    = '0;
        clear_cap();

        fork
            forever begin
                @(negedge clk);
                chk("cycle_outputs", 32'(dut_outs()), 32'(exp_outs()));
            end
        join_none

        // Reset with start already high, then a two-cycle init pulse.
        #12 rst_n = 1'b1;
        @(posedge clk); #2 init = 1'b1;
        run(2);
        chk("init_outputs", 32'(dut_outs()), 32'd0);
        #2 init = 1'b0;
        run(10);
        chk("held_start_no_launch", 32'(ns + int'(bus.busy)), 32'd0);
        bus.start = 1'b0;

        // One-shot frame, five ones in data -> parity 1.
        launch(SW_A, 1'b0);
        run(70);
        chk("oneshot_first_strobe", first_st, 1);
        chk("oneshot_symbols", 32'(cap[14:0]), 32'(15'b101010001101011));
        chk("oneshot_nsym", ns, 15);
        chk("oneshot_done_cycle", done_at, 61);
        chk("oneshot_ndone", ndone, 1);
        chk("oneshot_idle", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;

        // Mid-frame sw change and start edges while busy.
        launch(SW_A, 1'b0);
        run(10);
        bus.sw    = SW_B;
        bus.start = 1'b0;
        run(3);
        bus.start = 1'b1;
        run(60);
        chk("swchg_symbols", 32'(cap[14:0]), 32'(15'b101010001101011));
        chk("swchg_ndone", ndone, 1);
        run(10);
        chk("swchg_no_requeue", ns, 15);
        bus.start = 1'b0;

        // Repeat mode: six ones -> parity 0, frames back-to-back.
        launch(SW_B, 1'b1);
        run(120);
        chk("repeat_two_frames", 32'(cap[29:0]), 32'({15'b101010011011010, 15'b101010011011010}));
        chk("repeat_done_cycle", done_at, 61);
        chk("repeat_ndone", ndone, 1);
        run(10);
        bus.start = 1'b0;
        run(60);
        chk("repeat_nsym", ns, 45);
        chk("repeat_ndone_total", ndone, 3);
        chk("repeat_done_with_strobe", n_coinc, 2);
        chk("repeat_idle_after_drop", 32'(bus.busy), 32'd0);
        bus.mode = 1'b0;

        // Abort during DATA with init, then relaunch.
        launch(SW_A, 1'b0);
        run(20);
        #1 init = 1'b1;
        @(posedge clk); #2 init = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'({bus.busy, bus.sym_valid, bus.sym}), 32'd0);
        clear_cap();
        run(70);
        chk("abort_no_done", ndone, 0);
        chk("abort_no_symbols", ns, 0);
        launch(SW_A, 1'b0);
        run(61);
        chk("relaunch_first_strobe", first_st, 1);
        chk("relaunch_symbols", 32'(cap[14:0]), 32'(15'b101010001101011));
        chk("relaunch_done_cycle", done_at, 61);
        bus.start = 1'b0;

        // Init and start edge on the same clock: init wins.
        @(posedge clk); #2;
        bus.start = 1'b1;
        init      = 1'b1;
        @(negedge clk);
        chk("init_beats_start", 32'(bus.busy), 32'd0);
        @(posedge clk); #2;
        init      = 1'b0;
        bus.start = 1'b0;
        clear_cap();
        run(5);
        chk("init_start_no_frame", ns, 0);

        // Async reset between edges mid-frame.
        launch(SW_B, 1'b0);
        run(30);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk("async_reset_clears", 32'(dut_outs()), 32'd0);
        bus.start = 1'b0;
        #10 rst_n = 1'b1;
        run(5);
        chk("after_reset_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
